// File: rtl/read_response_tx.sv
// Read-response transmitter: snapshots status/error/memory/counter state on a
// read request and streams opcode + payload bytes over a valid/ready handshake.
// Also maintains the saturating nav/science image counters.
// Optional feature: define RESP_CHECKSUM_EN to append an XOR checksum byte.
module read_response_tx #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        sysClk,
    input  logic        reset_n,
    input  logic [7:0]  instruction,
    input  logic        valid_buffer_for_read,
    input  logic        proc_img_1_flag,
    input  logic        proc_img_2_flag,
    input  logic        erase_img_flag,
    input  logic        booting_cam_flag,
    input  logic [15:0] index_of_error,
    input  logic        camid_of_error,
    input  logic        cam_timeout_error_flag,
    input  logic        cap_failure_flag,
    input  logic        cam_undetected_flag,
    input  logic        write_fail_flag,
    input  logic        read_fail_flag,
    input  logic        erase_fail_flag,
    input  logic [23:0] jpg_size_MCB,
    input  logic        nav_img_added_flag_MCB,
    input  logic        science_img_added_flag_MCB,
    input  logic        clear_img_counts,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic [3:0]  tx_byte_num,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic        req_dropped
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef RESP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CKSUM = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_e;
`endif

    state_e            state_q, state_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic [3:0]        tx_byte_num_q, tx_byte_num_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_abort_q, frame_abort_d;
    logic              req_dropped_q, req_dropped_d;
    logic [TO_W-1:0]   stall_q, stall_d;
    logic [3:0][7:0]   payload_q, payload_d;
    logic [3:0]        last_num_q, last_num_d;
    logic [CNT_W-1:0]  nav_cnt_q, nav_cnt_d;
    logic [CNT_W-1:0]  sci_cnt_q, sci_cnt_d;
    logic [3:0][7:0]   new_payload;
    logic [3:0]        new_last;
`ifdef RESP_CHECKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    // Payload bytes and length for the opcode currently requested
    always_comb begin
        new_payload = '0;
        new_last    = 4'd1;
        case (instruction)
            8'h01: new_payload[0] = {4'b0000, booting_cam_flag, erase_img_flag,
                                     proc_img_2_flag, proc_img_1_flag};
            8'h02: begin
                new_payload[0] = {camid_of_error, 1'b0, erase_fail_flag, read_fail_flag,
                                  write_fail_flag, cam_undetected_flag, cap_failure_flag,
                                  cam_timeout_error_flag};
                new_payload[1] = index_of_error[15:8];
                new_payload[2] = index_of_error[7:0];
                new_payload[3] = 8'h00;
                new_last       = 4'd4;
            end
            8'h03: begin
                new_payload[0] = jpg_size_MCB[23:16];
                new_payload[1] = jpg_size_MCB[15:8];
                new_payload[2] = jpg_size_MCB[7:0];
                new_last       = 4'd3;
            end
            8'h04: begin
                new_payload[0] = 8'(nav_cnt_q);
                new_payload[1] = 8'(sci_cnt_q);
                new_last       = 4'd2;
            end
            default: new_payload[0] = 8'hEE;
        endcase
    end

    // Next-state, handshake, timeout and counter logic
    always_comb begin
        state_d       = state_q;
        tx_byte_d     = tx_byte_q;
        tx_valid_d    = tx_valid_q;
        tx_byte_num_d = tx_byte_num_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        req_dropped_d = 1'b0;
        stall_d       = stall_q;
        payload_d     = payload_q;
        last_num_d    = last_num_q;
`ifdef RESP_CHECKSUM_EN
        cksum_d       = cksum_q;
`endif

        nav_cnt_d = nav_cnt_q;
        sci_cnt_d = sci_cnt_q;
        if (clear_img_counts) begin
            nav_cnt_d = '0;
            sci_cnt_d = '0;
        end else begin
            if (nav_img_added_flag_MCB && (nav_cnt_q != CNT_MAX))
                nav_cnt_d = nav_cnt_q + CNT_W'(1);
            if (science_img_added_flag_MCB && (sci_cnt_q != CNT_MAX))
                sci_cnt_d = sci_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (valid_buffer_for_read) begin
                    state_d       = SEND;
                    tx_valid_d    = 1'b1;
                    tx_byte_d     = instruction;
                    tx_byte_num_d = 4'd0;
                    busy_d        = 1'b1;
                    stall_d       = '0;
                    payload_d     = new_payload;
                    last_num_d    = new_last;
`ifdef RESP_CHECKSUM_EN
                    cksum_d = instruction ^ new_payload[0] ^ new_payload[1]
                              ^ new_payload[2] ^ new_payload[3];
`endif
                end
            end
            default: begin
                if (valid_buffer_for_read)
                    req_dropped_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    stall_d    = '0;
                    tx_valid_d = 1'b0;
                    if ((state_q == SEND) && (tx_byte_num_q != last_num_q)) begin
                        tx_byte_num_d = tx_byte_num_q + 4'd1;
                        tx_byte_d     = payload_q[tx_byte_num_q[1:0]];
                    end
`ifdef RESP_CHECKSUM_EN
                    else if (state_q == SEND) begin
                        state_d       = CKSUM;
                        tx_byte_num_d = tx_byte_num_q + 4'd1;
                        tx_byte_d     = cksum_q;
                    end
`endif
                    else begin
                        state_d       = IDLE;
                        busy_d        = 1'b0;
                        frame_done_d  = 1'b1;
                        tx_byte_d     = '0;
                        tx_byte_num_d = '0;
                    end
                end else if (tx_valid_q) begin
                    if (stall_q == TO_LAST) begin
                        state_d       = IDLE;
                        tx_valid_d    = 1'b0;
                        busy_d        = 1'b0;
                        frame_abort_d = 1'b1;
                        tx_byte_d     = '0;
                        tx_byte_num_d = '0;
                        stall_d       = '0;
                    end else begin
                        stall_d = stall_q + TO_W'(1);
                    end
                end else begin
                    // Bubble cycle over: present the byte prepared last cycle
                    tx_valid_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sysClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tx_byte_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_byte_num_q <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            req_dropped_q <= 1'b0;
            stall_q       <= '0;
            payload_q     <= '0;
            last_num_q    <= '0;
            nav_cnt_q     <= '0;
            sci_cnt_q     <= '0;
`ifdef RESP_CHECKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tx_byte_q     <= tx_byte_d;
            tx_valid_q    <= tx_valid_d;
            tx_byte_num_q <= tx_byte_num_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            req_dropped_q <= req_dropped_d;
            stall_q       <= stall_d;
            payload_q     <= payload_d;
            last_num_q    <= last_num_d;
            nav_cnt_q     <= nav_cnt_d;
            sci_cnt_q     <= sci_cnt_d;
`ifdef RESP_CHECKSUM_EN
            cksum_q       <= cksum_d;
`endif
        end
    end

    assign tx_byte     = tx_byte_q;
    assign tx_valid    = tx_valid_q;
    assign tx_byte_num = tx_byte_num_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_read_response_tx.sv
// Randomized self-checking bench for read_response_tx with a frame-level model.
module tb_read_response_tx;

    localparam int unsigned TO_CYC = 16;
    localparam int          CMAX   = 255;

    logic        sysClk;
    logic        reset_n;
    logic [7:0]  instruction;
    logic        valid_buffer_for_read;
    logic        proc_img_1_flag, proc_img_2_flag, erase_img_flag, booting_cam_flag;
    logic [15:0] index_of_error;
    logic        camid_of_error;
    logic        cam_timeout_error_flag, cap_failure_flag, cam_undetected_flag;
    logic        write_fail_flag, read_fail_flag, erase_fail_flag;
    logic [23:0] jpg_size_MCB;
    logic        nav_img_added_flag_MCB, science_img_added_flag_MCB, clear_img_counts;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic [3:0]  tx_byte_num;
    logic        busy, frame_done, frame_abort, req_dropped;

    int n_checks;
    int n_pass;
    int nav_m;
    int sci_m;
    logic [7:0] exp_q[$];

    read_response_tx #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(8)) dut (
        .sysClk(sysClk), .reset_n(reset_n), .instruction(instruction),
        .valid_buffer_for_read(valid_buffer_for_read),
        .proc_img_1_flag(proc_img_1_flag), .proc_img_2_flag(proc_img_2_flag),
        .erase_img_flag(erase_img_flag), .booting_cam_flag(booting_cam_flag),
        .index_of_error(index_of_error), .camid_of_error(camid_of_error),
        .cam_timeout_error_flag(cam_timeout_error_flag), .cap_failure_flag(cap_failure_flag),
        .cam_undetected_flag(cam_undetected_flag), .write_fail_flag(write_fail_flag),
        .read_fail_flag(read_fail_flag), .erase_fail_flag(erase_fail_flag),
        .jpg_size_MCB(jpg_size_MCB), .nav_img_added_flag_MCB(nav_img_added_flag_MCB),
        .science_img_added_flag_MCB(science_img_added_flag_MCB),
        .clear_img_counts(clear_img_counts), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .tx_valid(tx_valid), .tx_byte_num(tx_byte_num), .busy(busy),
        .frame_done(frame_done), .frame_abort(frame_abort), .req_dropped(req_dropped)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock: update the counter model with the values driven into this edge
    task automatic tick();
        @(posedge sysClk);
        if (!reset_n) begin
            nav_m = 0;
            sci_m = 0;
        end else if (clear_img_counts) begin
            nav_m = 0;
            sci_m = 0;
        end else begin
            if (nav_img_added_flag_MCB && nav_m < CMAX) nav_m++;
            if (science_img_added_flag_MCB && sci_m < CMAX) sci_m++;
        end
        #1;
    endtask

    task automatic rand_pulses();
        nav_img_added_flag_MCB     = ($urandom_range(3) == 0);
        science_img_added_flag_MCB = ($urandom_range(3) == 0);
        clear_img_counts           = ($urandom_range(29) == 0);
    endtask

    task automatic no_pulses();
        nav_img_added_flag_MCB     = 1'b0;
        science_img_added_flag_MCB = 1'b0;
        clear_img_counts           = 1'b0;
    endtask

    task automatic mutate_inputs();
        {proc_img_1_flag, proc_img_2_flag, erase_img_flag, booting_cam_flag} = 4'($urandom);
        {cam_timeout_error_flag, cap_failure_flag, cam_undetected_flag,
         write_fail_flag, read_fail_flag, erase_fail_flag, camid_of_error} = 7'($urandom);
        index_of_error = 16'($urandom);
        jpg_size_MCB   = 24'($urandom);
    endtask

    // Expected frame from the current inputs and counter model
    task automatic build_exp(input logic [7:0] op);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(op);
        case (op)
            8'h01: exp_q.push_back({4'h0, booting_cam_flag, erase_img_flag,
                                    proc_img_2_flag, proc_img_1_flag});
            8'h02: begin
                exp_q.push_back({camid_of_error, 1'b0, erase_fail_flag, read_fail_flag,
                                 write_fail_flag, cam_undetected_flag, cap_failure_flag,
                                 cam_timeout_error_flag});
                exp_q.push_back(index_of_error[15:8]);
                exp_q.push_back(index_of_error[7:0]);
                exp_q.push_back(8'h00);
            end
            8'h03: begin
                exp_q.push_back(jpg_size_MCB[23:16]);
                exp_q.push_back(jpg_size_MCB[15:8]);
                exp_q.push_back(jpg_size_MCB[7:0]);
            end
            8'h04: begin
                exp_q.push_back(8'(nav_m));
                exp_q.push_back(8'(sci_m));
            end
            default: exp_q.push_back(8'hEE);
        endcase
`ifdef RESP_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
        x = 8'h00;
    endtask

    // Issue a request and check the whole frame; returns in the frame_done cycle
    task automatic run_frame(input logic [7:0] op, input int ready_pct, input int stall_at,
                             input int stall_len, input bit rand_in);
        int k, stall_left, run;
        bit stalled, drop_exp, done, r, xfer;
        logic [7:0] held_b;
        logic [3:0] held_n;
        k = 0; stall_left = stall_len; run = 0;
        stalled = 0; drop_exp = 0; done = 0;
        held_b = '0; held_n = '0;
        build_exp(op);
        instruction = op;
        valid_buffer_for_read = 1'b1;
        if (rand_in) rand_pulses();
        tick();
        valid_buffer_for_read = 1'b0;
        check("start_valid", 32'(tx_valid), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            if (rand_in) mutate_inputs();
            if (stalled) begin
                check("stall_byte", 32'(tx_byte), 32'(held_b));
                check("stall_num", 32'(tx_byte_num), 32'(held_n));
            end
            if (tx_valid && k == stall_at && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else if (run >= 8) r = 1'b1;
            else r = ($urandom_range(99) < ready_pct);
            tx_ready = r;
            xfer = tx_valid && r;
            if (xfer) begin
                check("byte", 32'(tx_byte), 32'(exp_q[k]));
                check("byte_num", 32'(tx_byte_num), 32'(k));
                k++;
                run = 0;
            end else if (tx_valid) run++;
            stalled = tx_valid && !r;
            held_b = tx_byte;
            held_n = tx_byte_num;
            drop_exp = 1'b0;
            if (rand_in && busy && $urandom_range(9) == 0) begin
                valid_buffer_for_read = 1'b1;
                instruction = 8'($urandom);
                drop_exp = 1'b1;
            end
            if (rand_in) rand_pulses();
            tick();
            valid_buffer_for_read = 1'b0;
            if (drop_exp) check("req_dropped", 32'(req_dropped), 32'd1);
            if (xfer && k == exp_q.size()) begin
                check("done_pulse", 32'(frame_done), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
                check("done_valid", 32'(tx_valid), 32'd0);
                done = 1'b1;
            end
        end
        tx_ready = 1'b0;
        no_pulses();
        if (!done) check("frame_end", 32'(k), 32'(exp_q.size()));
    endtask

    initial begin
        int cnt;
        logic [7:0] op;
        n_checks = 0; n_pass = 0; nav_m = 0; sci_m = 0;
        reset_n = 1'b0; instruction = '0; valid_buffer_for_read = 1'b0; tx_ready = 1'b0;
        {proc_img_1_flag, proc_img_2_flag, erase_img_flag, booting_cam_flag} = '0;
        index_of_error = '0; camid_of_error = 1'b0;
        {cam_timeout_error_flag, cap_failure_flag, cam_undetected_flag} = '0;
        {write_fail_flag, read_fail_flag, erase_fail_flag} = '0;
        jpg_size_MCB = '0;
        no_pulses();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte", 32'(tx_byte), 32'd0);
        check("rst_num", 32'(tx_byte_num), 32'd0);
        check("rst_flags", 32'({frame_done, frame_abort, req_dropped}), 32'd0);

        // Status read, tx_ready always high
        proc_img_1_flag = 1'b1; booting_cam_flag = 1'b1;
        run_frame(8'h01, 100, 0, 0, 1'b0);
        tick();
        check("done_one_cycle", 32'(frame_done), 32'd0);

        // Error read
        index_of_error = 16'hA55A; camid_of_error = 1'b1;
        write_fail_flag = 1'b1; cam_timeout_error_flag = 1'b1;
        run_frame(8'h02, 100, 0, 0, 1'b0);
        tick();

        // Backpressure with inputs changing mid-frame
        jpg_size_MCB = 24'h012345;
        run_frame(8'h03, 100, 1, 12, 1'b1);
        tick();

        // Counters: nav+clear together, then more nav
        repeat (3) begin nav_img_added_flag_MCB = 1'b1; tick(); end
        nav_img_added_flag_MCB = 1'b0;
        repeat (300) begin science_img_added_flag_MCB = 1'b1; tick(); end
        science_img_added_flag_MCB = 1'b0;
        nav_img_added_flag_MCB = 1'b1; clear_img_counts = 1'b1; tick();
        clear_img_counts = 1'b0;
        repeat (2) tick();
        no_pulses();
        run_frame(8'h04, 100, 0, 0, 1'b0);
        tick();
        // Counters without clear: saturation
        clear_img_counts = 1'b1; tick(); clear_img_counts = 1'b0;
        repeat (4) begin nav_img_added_flag_MCB = 1'b1; tick(); end
        nav_img_added_flag_MCB = 1'b0;
        repeat (300) begin science_img_added_flag_MCB = 1'b1; tick(); end
        no_pulses();
        run_frame(8'h04, 70, 0, 0, 1'b0);
        tick();

        // Timeout with a dropped request during the stall
        instruction = 8'h7F; valid_buffer_for_read = 1'b1; tx_ready = 1'b0;
        tick();
        valid_buffer_for_read = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && tx_valid; i++) begin
            check("to_byte", 32'(tx_byte), 32'h7F);
            if (i == 3) begin valid_buffer_for_read = 1'b1; instruction = 8'h01; end
            cnt++;
            tick();
            valid_buffer_for_read = 1'b0;
            if (i == 3) check("to_dropped", 32'(req_dropped), 32'd1);
        end
        check("to_cycles", 32'(cnt), 32'(TO_CYC));
        check("to_abort", 32'(frame_abort), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        tick();
        check("to_abort_once", 32'(frame_abort), 32'd0);

        // Reset during byte 2 of an error read
        repeat (2) begin nav_img_added_flag_MCB = 1'b1; tick(); end
        no_pulses();
        instruction = 8'h02; valid_buffer_for_read = 1'b1; tick();
        valid_buffer_for_read = 1'b0; tx_ready = 1'b1;
        repeat (4) tick();
        check("mid_num", 32'(tx_byte_num), 32'd2);
        tx_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_num", 32'(tx_byte_num), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("mid_rst_pulses", 32'({frame_done, frame_abort}), 32'd0);
        run_frame(8'h04, 100, 0, 0, 1'b0);
        tick();
        run_frame(8'h01, 100, 0, 0, 1'b0);

        // Randomized frames, sometimes back-to-back in the frame_done cycle
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(4))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h03;
                3: op = 8'h04;
                default: op = 8'($urandom);
            endcase
            mutate_inputs();
            run_frame(op, $urandom_range(40, 100), 0, 0, 1'b1);
            repeat ($urandom_range(2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
